// File: rtl/fir_stream_adapter_if.sv
// Purpose : handshake/bus bundle between fir_stream_adapter and its surroundings
//           (producer stream, serial FIR sample/result pins, consumer stream, status).
// Latency : none, wires only.
// Backpressure: in_ready/out_ready carry valid-ready flow control on the two streams.
// Modports:
//   master - the adapter: drives in_ready, fir_rst, fir_sample, out_valid, out_data,
//            fifo_level, underrun, overflow.
//   slave  - the environment (producer, FIR, consumer, status control).
interface fir_stream_adapter_if #(
  parameter int DATA_W     = 8,
  parameter int RES_W      = 10,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              fir_rst;
  logic [DATA_W-1:0] fir_sample;
  logic [RES_W-1:0]  fir_result;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              underrun;
  logic              overflow;
  logic              clr_status;

  modport master (
    input  in_valid, in_data, fir_result, out_ready, clr_status,
    output in_ready, fir_rst, fir_sample, out_valid, out_data,
           fifo_level, underrun, overflow
  );

  modport slave (
    output in_valid, in_data, fir_result, out_ready, clr_status,
    input  in_ready, fir_rst, fir_sample, out_valid, out_data,
           fifo_level, underrun, overflow
  );
endinterface

// File: rtl/fir_stream_adapter.sv
// Purpose : streaming front/back end for a 20-cycle time-multiplexed serial FIR;
//           FIFOs producer samples, feeds one per frame, re-issues each frame result.
// Latency : sample used within FIFO_DEPTH frames; result out 1 frame + 1 clk after FIR latch.
// Backpressure: in_ready = RUN && FIFO not full; a result not taken before the next
//           capture is overwritten and flagged in the sticky overflow bit.
// Ports   : clk, reset (async active-low) plus bus (fir_stream_adapter_if.master):
//           in_valid/in_ready/in_data producer stream, fir_rst/fir_sample/fir_result FIR side,
//           out_valid/out_ready/out_data consumer stream, fifo_level, underrun, overflow,
//           clr_status status.
// Option  : define FIR_ADAPT_UNDERRUN_HOLD_EN to repeat the last sample on underrun
//           instead of feeding zero.
module fir_stream_adapter #(
  parameter int DATA_W     = 8,
  parameter int RES_W      = 10,
  parameter int FRAME_LEN  = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  fir_stream_adapter_if.master      bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = $clog2(FRAME_LEN);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_init_cnt;
  logic                w_init_cnt_nxt;
  logic                w_fir_rst;
  logic                w_in_ready;

  logic [PH_W-1:0]     r_phase;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic [DATA_W-1:0]   r_fir_sample;
  logic                r_out_valid;
  logic [RES_W-1:0]    r_out_data;
  logic                r_underrun;
  logic                r_overflow;
  logic                r_prime;

  logic                w_run;
  logic                w_frame_end;
  logic                w_capture;
  logic                w_push;
  logic                w_pop;
  logic                w_underrun_evt;
  logic                w_overflow_evt;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // INIT holds the FIR in reset for two edges so that its one-hot counter sits on
  // clk_cnt[0] in the first RUN cycle, which is where phase 0 starts.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_fir_rst      = 1'b1;
    w_in_ready     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_cnt_nxt = 1'b1;
        if (r_init_cnt) begin
          w_state_nxt    = S_RUN;
          w_init_cnt_nxt = 1'b0;
        end
      end
      S_RUN: begin
        w_fir_rst  = 1'b0;
        w_in_ready = (r_level < LVL_W'(FIFO_DEPTH));
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // ---------------- frame phase ----------------
  assign w_run       = (r_state == S_RUN);
  assign w_frame_end = w_run && (r_phase == PH_W'(FRAME_LEN - 1));
  assign w_capture   = w_run && (r_phase == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
    end else if (!w_run) begin
      r_phase <= '0;
    end else if (r_phase == PH_W'(FRAME_LEN - 1)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // ---------------- input FIFO ----------------
  // A full FIFO refuses the push even when the frame-end pop frees a slot on the
  // same edge, keeping in_ready a function of registered state only.
  assign w_push         = bus.in_valid && w_in_ready;
  assign w_pop          = w_frame_end && (r_level != '0);
  assign w_underrun_evt = w_frame_end && (r_level == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // Sample register is loaded on the phase FRAME_LEN-1 edge so it is stable for the
  // whole of phase 0, when the FIR latches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fir_sample <= '0;
    end else if (w_pop) begin
      r_fir_sample <= r_mem[r_rptr];
`ifdef FIR_ADAPT_UNDERRUN_HOLD_EN
    end
`else
    end else if (w_underrun_evt) begin
      r_fir_sample <= '0;
    end
`endif
  end

  // ---------------- result capture ----------------
  // The first capture after entering RUN is skipped: the FIR has not finished a frame.
  assign w_overflow_evt = w_capture && !r_prime && r_out_valid && !bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prime     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      if (r_prime) begin
        r_prime <= 1'b0;
      end else begin
        r_out_data  <= bus.fir_result;
        r_out_valid <= 1'b1;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // ---------------- sticky status ----------------
  // A set event on the same edge as clr_status wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
      end else if (bus.clr_status) begin
        r_underrun <= 1'b0;
      end
      if (w_overflow_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_status) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.in_ready   = w_in_ready;
  assign bus.fir_rst    = w_fir_rst;
  assign bus.fir_sample = r_fir_sample;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.fifo_level = r_level;
  assign bus.underrun   = r_underrun;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_fir_stream_adapter.sv
// Purpose : self-checking bench for fir_stream_adapter with a behavioural serial FIR
//           (taps 1,2,3,4 on newest..oldest sample) hooked to its FIR side.
// Latency : directed cycle-accurate vectors; expected values are hand-computed.
// Backpressure: out_ready held high except across the overflow sequence.
module tb_fir_stream_adapter;
  localparam int DATA_W     = 8;
  localparam int RES_W      = 10;
  localparam int FRAME_LEN  = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int D          = -1;   // field not compared

`ifdef FIR_ADAPT_UNDERRUN_HOLD_EN
  localparam int UND_FS = 'h66;
  localparam int Y11    = 321;
  localparam int Y12    = 632;
  localparam int Y13    = 1020;
`else
  localparam int UND_FS = 0;
  localparam int Y11    = 219;
  localparam int Y12    = 326;
  localparam int Y13    = 408;
`endif

  logic clk;
  logic reset;

  fir_stream_adapter_if #(.DATA_W(DATA_W), .RES_W(RES_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fir_stream_adapter #(
    .DATA_W(DATA_W), .RES_W(RES_W), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural serial FIR: one-hot frame counter held at bit 0 by fir_rst, latches the
  // sample in slot 0, publishes the frame result at the end of slot FRAME_LEN-1.
  logic [FRAME_LEN-1:0] stub_cnt;
  logic [DATA_W-1:0]    x0, x1, x2, x3;
  logic [RES_W-1:0]     stub_res;

  always @(posedge clk) begin
    if (bus.fir_rst) begin
      stub_cnt <= FRAME_LEN'(1);
      x0 <= '0; x1 <= '0; x2 <= '0; x3 <= '0;
      stub_res <= '0;
    end else begin
      stub_cnt <= {stub_cnt[FRAME_LEN-2:0], stub_cnt[FRAME_LEN-1]};
      if (stub_cnt[0]) begin
        x0 <= bus.fir_sample; x1 <= x0; x2 <= x1; x3 <= x2;
      end
      if (stub_cnt[FRAME_LEN-1]) begin
        stub_res <= RES_W'(int'(x0) + 2 * int'(x1) + 3 * int'(x2) + 4 * int'(x3));
      end
    end
  end
  assign bus.fir_result = stub_res;

  int n_cmp;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_opt(input string nm, input logic [31:0] act, input int exp);
    if (exp >= 0) chk(nm, act, 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int n;      // clocks to hold inputs before comparing
    bit v;
    int d;
    bit ordy;
    bit clr;
    int e_ir;
    int e_lvl;
    int e_fs;
    int e_ov;
    int e_od;
    int e_un;
    int e_of;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit v, input int d, input bit ordy, input bit clr,
                     input int ir, input int lvl, input int fs, input int ov, input int od,
                     input int un, input int of);
    vec_t e;
    e.n = n; e.v = v; e.d = d; e.ordy = ordy; e.clr = clr;
    e.e_ir = ir; e.e_lvl = lvl; e.e_fs = fs; e.e_ov = ov; e.e_od = od;
    e.e_un = un; e.e_of = of;
    tbl.push_back(e);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"},  bus.in_ready,   0);
    chk({pfx, "_fir_rst"},   bus.fir_rst,    1);
    chk({pfx, "_fir_sample"},bus.fir_sample, 0);
    chk({pfx, "_out_valid"}, bus.out_valid,  0);
    chk({pfx, "_out_data"},  bus.out_data,   0);
    chk({pfx, "_underrun"},  bus.underrun,   0);
    chk({pfx, "_overflow"},  bus.overflow,   0);
    chk({pfx, "_level"},     bus.fifo_level, 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.clr_status = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Cycle numbers below count RUN clocks from the first RUN cycle (phase 0).
    // FIFO order 11,22,33,44,7F,00,00,00,05,66 -> frame samples s1..s10;
    // results y_k = s_k + 2s_{k-1} + 3s_{k-2} + 4s_{k-3}, visible in cycle 20(k+1)+1.
    //    n  v  data  ordy clr | ir lvl fs      ov od    un of
    add( 1, 1, 'h11, 1, 0,     1, 1, 0,      0, 0,    0, 0);   // c1: first capture skipped
    add( 1, 1, 'h22, 1, 0,     1, 2, 0,      0, 0,    0, 0);
    add( 1, 1, 'h33, 1, 0,     1, 3, 0,      0, 0,    0, 0);
    add( 1, 1, 'h44, 1, 0,     0, 4, 0,      0, 0,    0, 0);   // full
    add( 1, 1, 'h55, 1, 0,     0, 4, 0,      0, 0,    0, 0);   // refused
    add(14, 0, 0,    1, 0,     0, 4, 0,      0, 0,    0, 0);   // c19
    add( 1, 1, 'h77, 1, 0,     1, 3, 'h11,   0, 0,    0, 0);   // full + pop: 77 refused
    add( 1, 1, 'h7F, 1, 0,     0, 4, 'h11,   1, 0,    0, 0);   // c21: y0
    add( 1, 0, 0,    1, 0,     0, 4, 'h11,   0, 0,    0, 0);   // consumed
    add(18, 0, 0,    1, 0,     1, 3, 'h22,   0, 0,    0, 0);   // c40
    add( 1, 1, 0,    1, 0,     0, 4, 'h22,   1, 17,   0, 0);
    add(19, 0, 0,    1, 0,     1, 3, 'h33,   0, 17,   0, 0);   // c60
    add( 1, 1, 0,    1, 0,     0, 4, 'h33,   1, 68,   0, 0);
    add(19, 0, 0,    1, 0,     1, 3, 'h44,   0, 68,   0, 0);   // c80
    add( 1, 1, 0,    1, 0,     0, 4, 'h44,   1, 170,  0, 0);
    add(19, 0, 0,    1, 0,     1, 3, 'h7F,   0, 170,  0, 0);   // c100
    add( 1, 1, 'h05, 1, 0,     0, 4, 'h7F,   1, 340,  0, 0);
    add(19, 0, 0,    1, 0,     1, 3, 0,      0, 340,  0, 0);   // c120
    add( 1, 0, 0,    1, 0,     1, 3, 0,      1, 552,  0, 0);
    add(18, 0, 0,    1, 0,     1, 3, 0,      0, 552,  0, 0);   // c139
    add( 1, 1, 'h66, 1, 0,     1, 3, 0,      0, 552,  0, 0);   // push+pop: level held
    add( 1, 0, 0,    1, 0,     1, 3, 0,      1, 662,  0, 0);
    add(19, 0, 0,    1, 0,     1, 2, 0,      0, 662,  0, 0);   // c160
    add( 1, 0, 0,    1, 0,     1, 2, 0,      1, 653,  0, 0);
    add(19, 0, 0,    1, 0,     1, 1, 'h05,   0, 653,  0, 0);   // c180
    add( 1, 0, 0,    1, 0,     1, 1, 'h05,   1, 508,  0, 0);
    add(19, 0, 0,    1, 0,     1, 0, 'h66,   0, 508,  0, 0);   // c200
    add( 1, 0, 0,    1, 0,     1, 0, 'h66,   1, 5,    0, 0);
    add(19, 0, 0,    1, 0,     1, 0, UND_FS, 0, 5,    1, 0);   // c220: underrun
    add( 1, 0, 0,    1, 0,     1, 0, UND_FS, 1, 112,  1, 0);
    add( 1, 0, 0,    1, 0,     1, 0, D,      0, 112,  1, 0);
    add(19, 0, 0,    0, 0,     1, 0, D,      1, Y11,  1, 0);   // c241: held
    add(20, 0, 0,    0, 0,     1, 0, D,      1, Y12,  1, 1);   // c261: overwritten
    add(19, 0, 0,    0, 0,     1, 0, D,      1, Y12,  1, 1);   // c280
    add( 1, 0, 0,    0, 1,     1, 0, D,      1, Y13,  0, 1);   // clr vs new overflow
    add( 1, 0, 0,    0, 1,     1, 0, D,      1, Y13,  0, 0);   // clr alone
    add( 1, 1, 'hA1, 0, 0,     1, 1, D,      1, Y13,  0, 0);
    add( 1, 1, 'hA2, 0, 0,     1, 2, D,      1, Y13,  0, 0);
    add( 1, 1, 'hA3, 0, 0,     1, 3, D,      1, Y13,  0, 0);
    add( 5, 0, 0,    0, 0,     1, 3, D,      1, Y13,  0, 0);   // c290, phase 10

    // ---- reset state and INIT ----
    repeat (3) tick();
    chk_reset_vals("rst");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    reset = 1'b1;
    chk("init0_fir_rst",  bus.fir_rst,  1);
    chk("init0_in_ready", bus.in_ready, 0);
    tick();
    chk("init1_fir_rst",  bus.fir_rst,  1);
    chk("init1_in_ready", bus.in_ready, 0);
    tick();
    chk("run0_fir_rst",   bus.fir_rst,  0);
    chk("run0_in_ready",  bus.in_ready, 1);
    chk("run0_clk_cnt0",  stub_cnt[0],  1);
    chk("run0_level",     bus.fifo_level, 0);

    // ---- table ----
    foreach (tbl[i]) begin
      bus.in_valid   = tbl[i].v;
      bus.in_data    = DATA_W'(tbl[i].d);
      bus.out_ready  = tbl[i].ordy;
      bus.clr_status = tbl[i].clr;
      repeat (tbl[i].n) tick();
      chk_opt($sformatf("v%0d_in_ready", i),   bus.in_ready,   tbl[i].e_ir);
      chk_opt($sformatf("v%0d_level", i),      bus.fifo_level, tbl[i].e_lvl);
      chk_opt($sformatf("v%0d_fir_sample", i), bus.fir_sample, tbl[i].e_fs);
      chk_opt($sformatf("v%0d_out_valid", i),  bus.out_valid,  tbl[i].e_ov);
      chk_opt($sformatf("v%0d_out_data", i),   bus.out_data,   tbl[i].e_od);
      chk_opt($sformatf("v%0d_underrun", i),   bus.underrun,   tbl[i].e_un);
      chk_opt($sformatf("v%0d_overflow", i),   bus.overflow,   tbl[i].e_of);
    end
    bus.in_valid   = 1'b0;
    bus.clr_status = 1'b0;

    // ---- asynchronous reset mid-frame (phase 10, level 3, result pending) ----
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    chk("re_init0_fir_rst", bus.fir_rst, 1);
    tick();
    chk("re_init1_fir_rst", bus.fir_rst, 1);
    tick();
    chk("re_run0_fir_rst",  bus.fir_rst,  0);
    chk("re_run0_clk_cnt0", stub_cnt[0],  1);
    chk("re_run0_in_ready", bus.in_ready, 1);
    tick();
    chk("re_run1_prime_out_valid", bus.out_valid, 0);
    repeat (19) tick();
    // old FIFO contents gone: the first frame end finds the FIFO empty
    chk("re_run20_underrun",   bus.underrun,   1);
    chk("re_run20_fir_sample", bus.fir_sample, 0);
    chk("re_run20_level",      bus.fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
